// File: rtl/amo_sequencer_pkg.sv
// Shared core definitions for the RV32A atomic path: opcode encodings and
// the legality helper used by the MEM-stage sequencer.
package amo_sequencer_pkg;

    typedef enum logic [4:0] {
        AMO_ADD  = 5'b00000,
        AMO_SWAP = 5'b00001,
        AMO_LR   = 5'b00010,
        AMO_SC   = 5'b00011,
        AMO_XOR  = 5'b00100,
        AMO_OR   = 5'b01000,
        AMO_AND  = 5'b01100,
        AMO_MIN  = 5'b10000,
        AMO_MAX  = 5'b10100,
        AMO_MINU = 5'b11000,
        AMO_MAXU = 5'b11100
    } amo_op_t;

    localparam logic [2:0] AMO_W_FUN3 = 3'b010;

    function automatic logic amo_op_legal(input logic [4:0] f5);
        case (f5)
            AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR, AMO_AND,
            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: amo_op_legal = 1'b1;
            default:                              amo_op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational modify step of an AMO: a is the old memory word, b is rs2.
module amo_alu
    import amo_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  amo_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    always_comb begin
        y = b;
        case (op)
            AMO_ADD:  y = a + b;
            AMO_XOR:  y = a ^ b;
            AMO_AND:  y = a & b;
            AMO_OR:   y = a | b;
            AMO_MIN:  y = ($signed(a) < $signed(b)) ? a : b;
            AMO_MAX:  y = ($signed(a) > $signed(b)) ? a : b;
            AMO_MINU: y = (a < b) ? a : b;
            AMO_MAXU: y = (a > b) ? a : b;
            default:  y = b;
        endcase
    end

endmodule

// File: rtl/amo_sequencer.sv
// MEM-stage sequencer for LR.W / SC.W / AMO*.W: owns the reservation, runs the
// read-modify-write on the data port and freezes the pipeline until DONE.
module amo_sequencer
    import amo_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            is_atomic_mem,
    input  logic [4:0]      fun5_mem,
    input  logic [2:0]      fun3_mem,
    input  logic [XLEN-1:0] addr_mem,
    input  logic [XLEN-1:0] rs2_mem_data,
    input  logic            store_mem,
    input  logic            resv_clr,
    input  logic            advance,
    output logic            atomic_unit_stall,
    output logic [XLEN-1:0] amo_result,
    output logic            amo_fault,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic            resv_vld_q, resv_vld_d;
    logic [XLEN-3:0] resv_addr_q, resv_addr_d;
    logic [XLEN-1:0] old_q, old_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] alu_y;
    logic            resv_hit;
    amo_op_t         op;

    assign op         = amo_op_t'(fun5_mem);
    assign mem_addr   = {addr_mem[XLEN-1:2], 2'b00};
    assign resv_hit   = resv_vld_q && (resv_addr_q == addr_mem[XLEN-1:2]);
    assign amo_result = result_q;
    assign amo_fault  = fault_q;

    amo_alu #(.XLEN(XLEN)) u_alu (
        .op (op),
        .a  (old_q),
        .b  (rs2_mem_data),
        .y  (alu_y)
    );

    always_comb begin
        state_d           = state_q;
        resv_vld_d        = resv_vld_q;
        resv_addr_d       = resv_addr_q;
        old_d             = old_q;
        result_d          = result_q;
        fault_d           = fault_q;
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        atomic_unit_stall = 1'b0;
        mem_wdata         = (op == AMO_SC) ? rs2_mem_data : alu_y;

        case (state_q)
            IDLE: if (is_atomic_mem) begin
                atomic_unit_stall = 1'b1;
                fault_d           = 1'b0;
                if (addr_mem[1:0] != 2'b00 || fun3_mem != AMO_W_FUN3 || !amo_op_legal(fun5_mem)) begin
                    fault_d  = 1'b1;
                    result_d = '0;
                    state_d  = DONE;
                end else if (op == AMO_SC) begin
                    // Any SC consumes the reservation, whether it succeeds or not.
                    resv_vld_d = 1'b0;
                    if (resv_hit) begin
                        state_d = WR_REQ;
                    end else begin
                        result_d = XLEN'(1);
                        state_d  = DONE;
                    end
                end else begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                atomic_unit_stall = 1'b1;
                mem_req           = 1'b1;
                if (mem_gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                atomic_unit_stall = 1'b1;
                if (mem_rvalid) begin
                    old_d = mem_rdata;
                    if (op == AMO_LR) begin
                        resv_vld_d  = 1'b1;
                        resv_addr_d = addr_mem[XLEN-1:2];
                        result_d    = mem_rdata;
                        state_d     = DONE;
                    end else begin
                        state_d = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                atomic_unit_stall = 1'b1;
                mem_req           = 1'b1;
                mem_we            = 1'b1;
                if (mem_gnt) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                atomic_unit_stall = 1'b1;
                if (mem_rvalid) begin
                    result_d = (op == AMO_SC) ? '0 : old_q;
                    state_d  = DONE;
                end
            end
            DONE: if (advance) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Kills take priority over an LR setting the reservation in the same cycle.
        if (resv_clr || (store_mem && resv_addr_q == addr_mem[XLEN-1:2]))
            resv_vld_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            resv_vld_q  <= 1'b0;
            resv_addr_q <= '0;
            old_q       <= '0;
            result_q    <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            resv_vld_q  <= resv_vld_d;
            resv_addr_q <= resv_addr_d;
            old_q       <= old_d;
            result_q    <= result_d;
            fault_q     <= fault_d;
        end
    end

endmodule

// File: tb/tb_amo_sequencer.sv
// Directed bench for amo_sequencer with a small word memory responder.
module tb_amo_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        is_atomic_mem = 1'b0;
    logic [4:0]  fun5_mem = '0;
    logic [2:0]  fun3_mem = 3'b010;
    logic [31:0] addr_mem = '0;
    logic [31:0] rs2_mem_data = '0;
    logic        store_mem = 1'b0;
    logic        resv_clr = 1'b0;
    logic        advance = 1'b0;
    logic        atomic_unit_stall;
    logic [31:0] amo_result;
    logic        amo_fault;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        gnt_en = 1'b1;
    logic        rv_en = 1'b1;
    logic        pend;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] mem [0:255];
    int          ngnt, nwr;
    int          nchk = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    amo_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .is_atomic_mem(is_atomic_mem), .fun5_mem(fun5_mem),
        .fun3_mem(fun3_mem), .addr_mem(addr_mem), .rs2_mem_data(rs2_mem_data),
        .store_mem(store_mem), .resv_clr(resv_clr), .advance(advance),
        .atomic_unit_stall(atomic_unit_stall), .amo_result(amo_result), .amo_fault(amo_fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Grant in the request cycle, respond one cycle later (zero-wait when enabled).
    assign mem_gnt    = mem_req && gnt_en;
    assign mem_rvalid = pend && rv_en;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend      <= 1'b0;
            mem_rdata <= '0;
            ngnt      <= 0;
            nwr       <= 0;
        end else begin
            if (pl_en) mem[pl_idx] <= pl_data;
            if (mem_rvalid) pend <= 1'b0;
            if (mem_req && mem_gnt) begin
                pend <= 1'b1;
                ngnt <= ngnt + 1;
                if (mem_we) begin
                    mem[mem_addr[9:2]] <= mem_wdata;
                    nwr <= nwr + 1;
                end else begin
                    mem_rdata <= mem[mem_addr[9:2]];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = a[9:2]; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    function automatic logic [31:0] peek(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction

    task automatic start(input logic [4:0] f5, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        fun5_mem = f5; fun3_mem = f3; addr_mem = a; rs2_mem_data = d;
        is_atomic_mem = 1'b1; advance = 1'b0;
    endtask

    // From the detect cycle, count clock edges until the stall drops (DONE).
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        do begin
            @(posedge clk); lat++; @(negedge clk);
        end while (atomic_unit_stall && lat < 50);
        if (atomic_unit_stall) check({tag, "_timeout"}, 32'(atomic_unit_stall), 32'd0);
    endtask

    task automatic retire();
        advance = 1'b1;
        @(negedge clk);
        is_atomic_mem = 1'b0; advance = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [4:0] f5, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        start(f5, f3, a, d);
        wait_done(tag, lat);
        check({tag, "_result"}, amo_result, exp_res);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        retire();
    endtask

    localparam logic [4:0] F_ADD = 5'b00000, F_SWAP = 5'b00001, F_LR = 5'b00010,
                           F_SC = 5'b00011, F_MIN = 5'b10000, F_MINU = 5'b11000;

    logic [4:0]  tbl_op  [6] = '{5'b00100, 5'b01100, 5'b01000, 5'b10100, 5'b11100, 5'b00001};
    logic [31:0] tbl_exp [6] = '{32'h8F0F000F, 32'h000000F0, 32'h8F0F00FF,
                                 32'h0F0F00F0, 32'h800000FF, 32'h800000FF};

    initial begin
        int g0, lat;
        logic [31:0] a0;
        #2;
        check("rst_stall", 32'(atomic_unit_stall), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_result", amo_result, 32'd0);
        check("rst_fault", 32'(amo_fault), 32'd0);
        @(negedge clk); reset = 1'b0;

        // AMOADD
        preload(32'h100, 32'd5);
        g0 = ngnt;
        run_op("amoadd", F_ADD, 3'b010, 32'h100, 32'd3, 32'd5, 5);
        check("amoadd_mem", peek(32'h100), 32'd8);
        check("amoadd_gnts", 32'(ngnt - g0), 32'd2);
        check("amoadd_fault", 32'(amo_fault), 32'd0);

        // ADD wraps
        preload(32'h104, 32'hFFFFFFFF);
        run_op("addwrap", F_ADD, 3'b010, 32'h104, 32'd2, 32'hFFFFFFFF, 5);
        check("addwrap_mem", peek(32'h104), 32'd1);

        // LR/SC pair, then a second SC fails with no access
        preload(32'h200, 32'hAA);
        run_op("lr", F_LR, 3'b010, 32'h200, 32'd0, 32'hAA, 3);
        run_op("sc_pass", F_SC, 3'b010, 32'h200, 32'h55, 32'd0, 3);
        check("sc_pass_mem", peek(32'h200), 32'h55);
        g0 = ngnt;
        run_op("sc_again", F_SC, 3'b010, 32'h200, 32'h66, 32'd1, 1);
        check("sc_again_gnts", 32'(ngnt - g0), 32'd0);
        check("sc_again_mem", peek(32'h200), 32'h55);

        // Reservation killed by an ordinary store to the reserved word
        run_op("lr3", F_LR, 3'b010, 32'h300, 32'd0, 32'h0 | peek(32'h300), 3);
        @(negedge clk); store_mem = 1'b1; addr_mem = 32'h300;
        @(negedge clk); store_mem = 1'b0;
        g0 = ngnt;
        run_op("sc_store", F_SC, 3'b010, 32'h300, 32'h12, 32'd1, 1);
        check("sc_store_gnts", 32'(ngnt - g0), 32'd0);

        // Reservation killed by resv_clr
        run_op("lr3b", F_LR, 3'b010, 32'h300, 32'd0, peek(32'h300), 3);
        @(negedge clk); resv_clr = 1'b1;
        @(negedge clk); resv_clr = 1'b0;
        g0 = ngnt;
        run_op("sc_clr", F_SC, 3'b010, 32'h300, 32'h12, 32'd1, 1);
        check("sc_clr_gnts", 32'(ngnt - g0), 32'd0);

        // Store to a different word leaves the reservation alone
        preload(32'h310, 32'h1);
        run_op("lr4", F_LR, 3'b010, 32'h310, 32'd0, 32'h1, 3);
        @(negedge clk); store_mem = 1'b1; addr_mem = 32'h314;
        @(negedge clk); store_mem = 1'b0;
        run_op("sc_other", F_SC, 3'b010, 32'h310, 32'h9, 32'd0, 3);
        check("sc_other_mem", peek(32'h310), 32'h9);

        // Signed vs unsigned min
        preload(32'h20C, 32'hFFFFFFFF);
        run_op("amomin", F_MIN, 3'b010, 32'h20C, 32'd1, 32'hFFFFFFFF, 5);
        check("amomin_mem", peek(32'h20C), 32'hFFFFFFFF);
        preload(32'h20C, 32'hFFFFFFFF);
        run_op("amominu", F_MINU, 3'b010, 32'h20C, 32'd1, 32'hFFFFFFFF, 5);
        check("amominu_mem", peek(32'h20C), 32'd1);

        // Remaining ALU ops: mem=0x0F0F00F0, rs2=0x800000FF
        for (int i = 0; i < 6; i++) begin
            preload(32'h240, 32'h0F0F00F0);
            run_op($sformatf("alu%0d", i), tbl_op[i], 3'b010, 32'h240, 32'h800000FF, 32'h0F0F00F0, 5);
            check($sformatf("alu%0d_mem", i), peek(32'h240), tbl_exp[i]);
        end

        // Faults: misaligned, bad width, bad opcode
        g0 = ngnt;
        run_op("f_mis", F_SWAP, 3'b010, 32'h102, 32'd7, 32'd0, 1);
        check("f_mis_fault", 32'(amo_fault), 32'd1);
        run_op("f_w", F_SWAP, 3'b011, 32'h100, 32'd7, 32'd0, 1);
        check("f_w_fault", 32'(amo_fault), 32'd1);
        run_op("f_op", 5'b00101, 3'b010, 32'h100, 32'd7, 32'd0, 1);
        check("f_op_fault", 32'(amo_fault), 32'd1);
        check("f_gnts", 32'(ngnt - g0), 32'd0);
        check("f_mem", peek(32'h100), 32'd8);

        // Backpressure on the read request, then a held DONE
        preload(32'h140, 32'd10);
        gnt_en = 1'b0;
        start(F_ADD, 3'b010, 32'h144, 32'd1);
        addr_mem = 32'h140;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("bp_req%0d", i), 32'(mem_req), 32'd1);
            check($sformatf("bp_we%0d", i), 32'(mem_we), 32'd0);
            check($sformatf("bp_addr%0d", i), mem_addr, 32'h140);
            check($sformatf("bp_stall%0d", i), 32'(atomic_unit_stall), 32'd1);
        end
        gnt_en = 1'b1;
        wait_done("bp", lat);
        check("bp_result", amo_result, 32'd10);
        check("bp_mem", peek(32'h140), 32'd11);
        g0 = ngnt;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("hold_stall%0d", i), 32'(atomic_unit_stall), 32'd0);
            check($sformatf("hold_req%0d", i), 32'(mem_req), 32'd0);
        end
        check("hold_gnts", 32'(ngnt - g0), 32'd0);
        check("hold_result", amo_result, 32'd10);
        retire();

        // Reset in RD_WAIT clears everything, including the reservation
        preload(32'h180, 32'h77);
        run_op("lr5", F_LR, 3'b010, 32'h180, 32'd0, 32'h77, 3);
        rv_en = 1'b0;
        start(F_ADD, 3'b010, 32'h1C0, 32'd1);
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rw_stall", 32'(atomic_unit_stall), 32'd1);
        check("rw_req", 32'(mem_req), 32'd0);
        is_atomic_mem = 1'b0;
        reset = 1'b1;
        #1;
        check("rw_rst_stall", 32'(atomic_unit_stall), 32'd0);
        check("rw_rst_req", 32'(mem_req), 32'd0);
        check("rw_rst_result", amo_result, 32'd0);
        @(negedge clk); reset = 1'b0; rv_en = 1'b1;
        a0 = peek(32'h180);
        g0 = ngnt;
        run_op("sc_after_rst", F_SC, 3'b010, 32'h180, 32'h99, 32'd1, 1);
        check("sc_after_rst_gnts", 32'(ngnt - g0), 32'd0);
        check("sc_after_rst_mem", peek(32'h180), a0);

        // Reset while the read request is pending drops mem_req without a clock edge
        gnt_en = 1'b0;
        start(F_ADD, 3'b010, 32'h1C0, 32'd1);
        @(posedge clk); @(negedge clk);
        check("rq_req", 32'(mem_req), 32'd1);
        #2;
        is_atomic_mem = 1'b0;
        reset = 1'b1;
        #1;
        check("rq_rst_req", 32'(mem_req), 32'd0);
        @(negedge clk); reset = 1'b0; gnt_en = 1'b1;
        @(negedge clk);
        check("rq_idle_req", 32'(mem_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
